// File: rtl/mul16_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier: one 17-bit add and shift per clock.
// MUL16_HIGH_PRODUCT_EN enables the registered high half of the product on out_hi.
module mul16_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] out,
    output logic [15:0] out_hi
);

    // state  | meaning
    // S_IDLE | waiting for start; operands captured on the accepting edge
    // S_BUSY | 16 add/shift iterations
    // S_DONE | one-cycle done pulse, then back to idle
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] mcand_q, mcand_d;
    logic [32:0] p_q, p_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] res_lo_q, res_lo_d;
    logic [16:0] sum;
    logic [32:0] p_shift;

    // p[32:16] is the accumulator, p[15:0] the multiplier being shifted out
    always_comb begin
        sum     = p_q[32:16] + {1'b0, (p_q[0] ? mcand_q : 16'h0000)};
        p_shift = {1'b0, sum, p_q[15:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mcand_q  <= 16'h0000;
            p_q      <= 33'd0;
            cnt_q    <= 4'd0;
            res_lo_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            p_q      <= p_d;
            cnt_q    <= cnt_d;
            res_lo_q <= res_lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        res_lo_d = res_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d = a;
                    p_d     = {17'd0, b};
                    cnt_d   = 4'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                p_d   = p_shift;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    res_lo_d = p_shift[15:0];
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef MUL16_HIGH_PRODUCT_EN
    logic [15:0] res_hi_q, res_hi_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) res_hi_q <= 16'h0000;
        else       res_hi_q <= res_hi_d;
    end

    always_comb begin
        res_hi_d = res_hi_q;
        if (state_q == S_BUSY && cnt_q == 4'd15) res_hi_d = p_shift[31:16];
    end

    assign out_hi = res_hi_q;
`else
    assign out_hi = 16'h0000;
`endif

    always_comb begin
        busy = (state_q == S_BUSY);
        done = (state_q == S_DONE);
        out  = res_lo_q;
    end

endmodule

// File: tb/tb_mul16_seq.sv
// Directed bench for mul16_seq: vector table plus hand-written handshake corner sequences.
module tb_mul16_seq;

`ifdef MUL16_HIGH_PRODUCT_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] a, b;
    logic        busy, done;
    logic [15:0] out, out_hi;

    int checks = 0;
    int errors = 0;
    int overlap = 0;
    logic [15:0] last_lo = 16'h0000;
    logic [15:0] last_hi = 16'h0000;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
    } vec_t;
    vec_t vecs[8];

    mul16_seq dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .out   (out),
        .out_hi(out_hi)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy && done) overlap++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] hi_of(input logic [31:0] p);
        return HI_EN ? p[31:16] : 16'h0000;
    endfunction

    // One full operation from idle; also checks that the previous result is held while busy.
    task automatic do_mul(input logic [15:0] av, input logic [15:0] bv,
                          input logic [31:0] prod, input string name);
        int  n;
        bit  held;
        @(negedge clk);
        a = av; b = bv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        n = 0; held = 1'b1;
        while (busy && n < 40) begin
            n++;
            if (out !== last_lo || out_hi !== last_hi) held = 1'b0;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, n, 16);
        check({name, "_held"}, {31'd0, held}, 1);
        check({name, "_done"}, {31'd0, done}, 1);
        check({name, "_out"}, {16'd0, out}, {16'd0, prod[15:0]});
        check({name, "_out_hi"}, {16'd0, out_hi}, {16'd0, hi_of(prod)});
        @(negedge clk);
        check({name, "_done_fall"}, {31'd0, done}, 0);
        last_lo = prod[15:0];
        last_hi = hi_of(prod);
    endtask

    initial begin
        int n, dones, busys, rises;
        int rise_at[4];
        logic        prev_busy;
        logic [15:0] prev_out;
        bit          stable;

        vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
        vecs[2] = '{16'h0100, 16'h0100, 32'h0001_0000};
        vecs[3] = '{16'h0000, 16'h1234, 32'h0000_0000};
        vecs[4] = '{16'h1234, 16'h5678, 32'h0626_0060};
        vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
        vecs[6] = '{16'h8000, 16'h0002, 32'h0001_0000};
        vecs[7] = '{16'h0001, 16'h8000, 32'h0000_8000};

        reset = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_out", {16'd0, out}, 0);
        check("rst_out_hi", {16'd0, out_hi}, 0);

        for (int i = 0; i < 8; i++)
            do_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // start pulses during BUSY and during DONE must be ignored
        @(negedge clk);
        a = 16'd7; b = 16'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        a = 16'd2; b = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin n++; @(negedge clk); end
        check("ign_done_seen", {31'd0, done}, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_no_restart", {31'd0, busy}, 0);
        dones = 0; busys = 0;
        for (int k = 0; k < 24; k++) begin
            if (done) dones++;
            if (busy) busys++;
            @(negedge clk);
        end
        check("ign_extra_done", dones, 0);
        check("ign_extra_busy", busys, 0);
        check("ign_out", {16'd0, out}, 32'h3F);
        check("ign_out_hi", {16'd0, out_hi}, 0);
        last_lo = 16'h003F; last_hi = 16'h0000;

        // reset in the middle of an operation
        a = 16'd10; b = 16'd10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_done", {31'd0, done}, 0);
        check("mid_rst_out", {16'd0, out}, 0);
        check("mid_rst_out_hi", {16'd0, out_hi}, 0);
        @(negedge clk);
        reset = 1'b0;
        last_lo = 16'h0; last_hi = 16'h0;
        n = 0; dones = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy) n++;
            if (done) dones++;
            @(negedge clk);
        end
        check("mid_discarded_busy", n, 0);
        check("mid_discarded_done", dones, 0);
        do_mul(16'd4, 16'd4, 32'h0000_0010, "post_rst");

        // start held high: accepted only when back in IDLE
        a = 16'd6; b = 16'd7; start = 1'b1;
        dones = 0; rises = 0; stable = 1'b1;
        prev_busy = 1'b0; prev_out = out;
        @(negedge clk);
        for (int k = 0; k < 54; k++) begin
            if (busy && !prev_busy && rises < 4) begin rise_at[rises] = k; rises++; end
            if (done) begin
                dones++;
                check($sformatf("cont_out%0d", dones), {16'd0, out}, 32'h2A);
            end
            if (out !== prev_out && !done) stable = 1'b0;
            prev_busy = busy; prev_out = out;
            @(negedge clk);
        end
        start = 1'b0;
        check("cont_dones", dones, 3);
        check("cont_accepts", rises, 3);
        if (rises >= 3) begin
            check("cont_period1", rise_at[1] - rise_at[0], 18);
            check("cont_period2", rise_at[2] - rise_at[1], 18);
        end
        check("cont_out_stable", {31'd0, stable}, 1);
        n = 0;
        while ((busy || done) && n < 40) begin n++; @(negedge clk); end
        check("drain_idle", {30'd0, busy, done}, 0);

        check("busy_done_overlap", overlap, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
